// File: rtl/frame_majority_defs.sv
// frame_majority_defs
//   Shared definitions for the frame majority counter: the FSM state
//   encoding and the two-bit verdict codes presented on the result port.
//   No ports; imported by the top module.
package frame_majority_defs;

  // IDLE: no word of the current frame taken yet
  // ACCUM: between 1 and FRAME_LEN-1 words taken
  // DONE: verdict registered and held until the consumer takes it
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Verdict codes; 2'b11 is never produced
  localparam logic [1:0] RES_ZEROS = 2'b00;
  localparam logic [1:0] RES_ONES  = 2'b01;
  localparam logic [1:0] RES_TIE   = 2'b10;

endpackage

// File: rtl/popcount_word.sv
// popcount_word
//   Purely combinational count of the set bits in one input word.
//   The zeros count of the same word is WIDTH minus this result.
// Ports:
//   data   input  WIDTH   word to count
//   count  output CNT_W   number of ones in data
module popcount_word #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Ripple sum of the individual bits; synthesis turns this into an adder tree
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/frame_majority_counter.sv
// frame_majority_counter
//   Counts ones and zeros over a frame of up to FRAME_LEN words and, after
//   the frame's last word, holds the majority verdict plus both counts on a
//   valid/ready output until the consumer takes it.
// Ports:
//   clk        input   1      rising-edge clock
//   reset_n    input   1      synchronous active-low reset
//   clear      input   1      synchronous abort of the current frame
//   in_valid   input   1      in_data / in_last valid
//   in_ready   output  1      block can accept a word (not in DONE)
//   in_data    input   WIDTH  word to count
//   in_last    input   1      this word ends the frame early
//   out_valid  output  1      verdict and counts valid
//   out_ready  input   1      consumer takes the verdict
//   result     output  2      00 zeros majority, 01 ones majority, 10 tie
//   cnt1       output  CNT_W  ones in the frame
//   cnt0       output  CNT_W  zeros in the frame
module frame_majority_counter
  import frame_majority_defs::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = $clog2(WIDTH * FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       result,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt0
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  // A one-word frame still needs a one-bit index so the vector is legal
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc1;
  logic [CNT_W-1:0] acc0;
  logic [CNT_W-1:0] sum1;
  logic [CNT_W-1:0] sum0;
  logic [PC_W-1:0]  pc;
  logic             accept;
  logic             final_word;
  logic             handshake;

  popcount_word #(
    .WIDTH (WIDTH),
    .CNT_W (PC_W)
  ) u_popcount (
    .data  (in_data),
    .count (pc)
  );

  // Accept and frame-end qualification, plus the running totals that
  // include the word currently on the bus. in_last on the FRAME_LEN-th word
  // simply makes both end conditions true; it is still one frame end.
  always_comb begin
    accept     = in_valid && (state != ST_DONE);
    final_word = accept && (in_last || (idx == IDX_W'(FRAME_LEN - 1)));
    handshake  = (state == ST_DONE) && out_ready;
    sum1       = acc1 + CNT_W'(pc);
    sum0       = acc0 + (CNT_W'(WIDTH) - CNT_W'(pc));
  end

  // State register; reset outranks everything, the rest is in next-state logic
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clear aborts the frame from any state, including DONE
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (final_word) begin
            state_nxt = ST_DONE;
          end else if (accept) begin
            state_nxt = ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (handshake) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state
  always_comb begin
    in_ready  = (state != ST_DONE);
    out_valid = (state == ST_DONE);
  end

  // Accumulators, word index and registered verdict. On the final word the
  // verdict is taken from the totals including that word, and the
  // accumulators are zeroed straight away so the next frame starts clean.
  // The verdict registers keep their values through a clear or a handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc1   <= '0;
      acc0   <= '0;
      idx    <= '0;
      cnt1   <= '0;
      cnt0   <= '0;
      result <= RES_ZEROS;
    end else if (clear) begin
      acc1 <= '0;
      acc0 <= '0;
      idx  <= '0;
    end else if (final_word) begin
      cnt1 <= sum1;
      cnt0 <= sum0;
      if (sum1 < sum0) begin
        result <= RES_ZEROS;
      end else if (sum1 > sum0) begin
        result <= RES_ONES;
      end else begin
        result <= RES_TIE;
      end
      acc1 <= '0;
      acc0 <= '0;
      idx  <= '0;
    end else if (accept) begin
      acc1 <= sum1;
      acc0 <= sum0;
      idx  <= idx + IDX_W'(1);
    end else if (handshake) begin
      acc1 <= '0;
      acc0 <= '0;
      idx  <= '0;
    end
  end

endmodule

// File: doc/frame_majority_counter.md
Name: frame_majority_counter

Overview:
- Streaming, parametrised successor to the single-word ones/zeros comparator.
- Accepts a frame of up to FRAME_LEN words of WIDTH bits over a valid/ready input, counting ones and zeros across the whole frame.
- After the frame's last word it presents the majority verdict plus both counts on a valid/ready output, held until consumed.
- Sits between a word-producing datapath stage and a consumer that needs frame-level bit statistics.

Parameters:
- WIDTH, 8, bits per input word (>=1).
- FRAME_LEN, 4, maximum words per frame (>=1).
- CNT_W, $clog2(WIDTH*FRAME_LEN+1), width of the count outputs.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous abort of the current frame.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to count.
- in_last  input  1  this word ends the frame early.
- out_valid  output  1  verdict/counts valid.
- out_ready  input  1  consumer takes the verdict.
- result  output  2  00 = zeros majority, 01 = ones majority, 10 = tie, 11 = never driven.
- cnt1  output  CNT_W  ones in the frame.
- cnt0  output  CNT_W  zeros in the frame.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low: reset_n sampled low at a rising edge puts the block in IDLE with out_valid=0, result=00, cnt1=0, cnt0=0, word index=0.
  - reset_n low between edges has no effect until the next edge.
  - Reset has priority over clear; clear has priority over everything else.
- States: IDLE (no word yet), ACCUM (1..FRAME_LEN-1 words taken), DONE (verdict held).
- Ready and accept:
  - in_ready = (state != DONE); it is 1 out of reset.
  - A word is accepted only when in_valid && in_ready. Cycles with in_valid=0 do not count.
- Accumulation on each accepted word:
  - ones accumulator += popcount(in_data); zeros accumulator += WIDTH - popcount(in_data).
  - Arithmetic is CNT_W wide and cannot overflow by construction.
- Frame end:
  - The frame ends on the accepted word with in_last=1, or on the accepted word with index FRAME_LEN-1, whichever comes first.
  - On that edge: the state moves to DONE; cnt1/cnt0 are registered including that word; result is registered.
  - result rule: cnt1<cnt0 gives 00, cnt1>cnt0 gives 01, equal gives 10.
  - out_valid is 1 in the cycle after the last word's acceptance, so latency is 1 cycle.
- Transitions:
  - IDLE to ACCUM on a non-final accept. IDLE to DONE on a final accept (single-word frame).
  - ACCUM to DONE on a final accept.
  - DONE to IDLE on out_valid && out_ready. At that edge out_valid clears, the accumulators and word index zero, and cnt1/cnt0/result keep their last values (don't-care while out_valid=0).
  - Earliest next-frame accept is the cycle after the output handshake.
- Backpressure: in DONE, result/cnt1/cnt0 stay stable until the handshake. in_valid is ignored (in_ready=0) and no word is lost or counted.
- clear:
  - Zeros the accumulators and word index, forces IDLE and out_valid=0.
  - A word presented in the same cycle is dropped.
  - clear in DONE discards the pending verdict.
- in_last on an accept whose index is already FRAME_LEN-1: a single frame end, with no double counting.

Decomposition:
- Shared package/header (frame_majority_defs) holds:
  - result codes RES_ZEROS=2'b00, RES_ONES=2'b01, RES_TIE=2'b10;
  - state encodings ST_IDLE, ST_ACCUM, ST_DONE.
- One natural sub-module: popcount_word, a combinational WIDTH-bit ones counter with output width $clog2(WIDTH+1). It is reused for the zeros count as WIDTH minus its output.
- The FSM, accumulators and output registers stay in the top module.

Test Plan:
- WIDTH=8, FRAME_LEN=4, back-to-back words FF, FF, 0F, 00 -> one cycle after the 4th accept: out_valid=1, cnt1=20, cnt0=12, result=01.
- Words F0, 0F, AA, 55 with 2-cycle in_valid gaps between them -> gaps not counted; cnt1=16, cnt0=16, result=10.
- Single word 01 with in_last=1 from IDLE -> next cycle out_valid=1, cnt1=1, cnt0=7, result=00; then IDLE after the handshake.
- out_ready=0 for 5 cycles with in_valid=1 and in_data=FF during DONE:
  - in_ready=0 and outputs stable throughout;
  - out_ready=1 completes the handshake and in_ready=1 next cycle;
  - a following FF x4 frame gives cnt1=32, cnt0=0, result=01.
- clear asserted together with the 3rd word of a frame (FF, FF, FF) -> IDLE, 3rd word dropped; next frame 00 x4 gives cnt1=0, cnt0=32, result=00.
- reset_n pulled low mid-cycle in ACCUM and held 1 edge -> no change before the edge; after the edge out_valid=0, result=00, counts 0, in_ready=1; repeat with reset_n low in DONE.
